// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS counter built from per-bit toggle stages (q <= q ^ t_vec).
// Define TFF_CNT_UPDOWN_EN to add the i_dir port and down counting.
module tff_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
`ifdef TFF_CNT_UPDOWN_EN
  input  logic             i_dir,
`endif
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_co
);

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] r_q;
  logic             r_co;
  logic [WIDTH-1:0] w_ones_below;
  logic [WIDTH-1:0] w_t_vec;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_oor;
  logic             w_load_ok;
  logic             w_down;

  // Toggle term for bit i: all lower bits set (up).
  assign w_ones_below[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_up_chain
    assign w_ones_below[i] = w_ones_below[i-1] & r_q[i-1];
  end

  assign w_at_max  = (r_q == LP_MAX);
  assign w_at_zero = (r_q == '0);
  assign w_oor     = ({1'b0, r_q} >= LP_MOD);
  assign w_load_ok = ({1'b0, i_load_val} < LP_MOD);

`ifdef TFF_CNT_UPDOWN_EN
  logic [WIDTH-1:0] w_zeros_below;

  assign w_zeros_below[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_dn_chain
    assign w_zeros_below[i] = w_zeros_below[i-1] & ~r_q[i-1];
  end

  assign w_down = i_dir;

  always_comb begin
    w_t_vec = '0;
    if (i_en) begin
      if (w_oor)
        w_t_vec = r_q;                 // clear any illegal state
      else if (w_down)
        w_t_vec = w_at_zero ? (r_q ^ LP_MAX) : w_zeros_below;
      else
        w_t_vec = w_at_max ? r_q : w_ones_below;
    end
  end
`else
  assign w_down = 1'b0;

  always_comb begin
    w_t_vec = '0;
    if (i_en) begin
      if (w_oor || w_at_max)
        w_t_vec = r_q;                 // wrap / clear illegal state
      else
        w_t_vec = w_ones_below;
    end
  end
`endif

  assign o_tc = i_en & (w_down ? w_at_zero : w_at_max);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q  <= '0;
      r_co <= 1'b0;
    end else if (i_load) begin
      r_q  <= w_load_ok ? i_load_val : '0;
      r_co <= 1'b0;
    end else begin
      r_q  <= r_q ^ w_t_vec;
      r_co <= o_tc;
    end
  end

  assign o_q  = r_q;
  assign o_co = r_co;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Scoreboard bench for tff_mod_counter (WIDTH=4, MODULUS=10); down-count
// section is built only when TFF_CNT_UPDOWN_EN is defined.
module tb_tff_mod_counter;
  localparam int W   = 4;
  localparam int MOD = 10;

  typedef struct packed {
    logic [W-1:0] q;
    logic         co;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         dir = 1'b0;
  logic [W-1:0] q;
  logic         tc;
  logic         co;

  int   n_chk = 0;
  int   n_fail = 0;
  int   m_q = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  tff_mod_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_load     (load),
    .i_load_val (load_val),
`ifdef TFF_CNT_UPDOWN_EN
    .i_dir      (dir),
`endif
    .o_q        (q),
    .o_tc       (tc),
    .o_co       (co)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // One clock: drive, check lookahead tc, push expected, compare after edge.
  task automatic step(input logic a_rst, input logic a_en, input logic a_load,
                      input logic [W-1:0] a_lv, input bit a_chk_tc);
    exp_t e;
    bit   tc_e;
    int   nq;
    @(negedge clk);
    rst = a_rst; en = a_en; load = a_load; load_val = a_lv;
    #1;
    tc_e = a_en && (dir ? (m_q == 0) : (m_q == MOD - 1));
    if (a_chk_tc) chk("tc", {31'd0, tc}, {31'd0, tc_e});
    if (a_rst)       nq = 0;
    else if (a_load) nq = (int'(a_lv) < MOD) ? int'(a_lv) : 0;
    else if (a_en) begin
      if (m_q >= MOD)  nq = 0;
      else if (dir)    nq = (m_q == 0) ? MOD - 1 : m_q - 1;
      else             nq = (m_q == MOD - 1) ? 0 : m_q + 1;
    end else           nq = m_q;
    e.q  = W'(nq);
    e.co = tc_e && !a_load && !a_rst;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("q", {28'd0, q}, {28'd0, e.q});
    chk("co", {31'd0, co}, {31'd0, e.co});
    m_q = int'(e.q);
  endtask

  initial begin
    int pulses;
    int last_pulse;
    int gap_bad;
    // Reset with en held high.
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    // Count up to 9.
    for (int i = 0; i < 9; i++) step(0, 1, 0, 0, 1);
    chk("q_at_9", {28'd0, q}, 32'd9);
    chk("tc_at_9", {31'd0, tc}, 32'd1);
    // 30 enabled cycles: three wrap pulses 10 apart.
    pulses = 0; last_pulse = -1; gap_bad = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 1, 0, 0, 1);
      if (co === 1'b1) begin
        if (last_pulse >= 0 && i - last_pulse != 10) gap_bad++;
        last_pulse = i;
        pulses++;
      end
    end
    chk("co_pulses", pulses, 32'd3);
    chk("co_gap", gap_bad, 32'd0);
    // Enable gating from 3.
    step(0, 0, 1, 4'd3, 1);
    step(0, 1, 0, 0, 1); chk("gate_1", {28'd0, q}, 32'd4);
    step(0, 0, 0, 0, 1); chk("gate_0", {28'd0, q}, 32'd4);
    step(0, 1, 0, 0, 1); chk("gate_2", {28'd0, q}, 32'd5);
    step(0, 0, 0, 0, 1); chk("gate_3", {28'd0, q}, 32'd5);
    // Loads, including out-of-range and load-over-terminal.
    step(0, 0, 1, 4'd7, 1);  chk("load_7", {28'd0, q}, 32'd7);
    step(0, 0, 1, 4'd12, 1); chk("load_12", {28'd0, q}, 32'd0);
    step(0, 0, 1, 4'd15, 1); chk("load_15", {28'd0, q}, 32'd0);
    step(0, 0, 1, 4'd9, 1);
    step(0, 1, 1, 4'd5, 1);
    chk("load_wins_q", {28'd0, q}, 32'd5);
    chk("load_wins_co", {31'd0, co}, 32'd0);
    // Reset mid-count.
    step(0, 0, 1, 4'd6, 1);
    step(1, 1, 0, 0, 1); chk("midrst_q", {28'd0, q}, 32'd0);
    step(0, 1, 0, 0, 1); chk("after_rst", {28'd0, q}, 32'd1);
`ifdef TFF_CNT_UPDOWN_EN
    step(0, 0, 1, 4'd1, 1);
    dir = 1'b1;
    step(0, 1, 0, 0, 1); chk("dn_q0", {28'd0, q}, 32'd0);
    step(0, 1, 0, 0, 1); chk("dn_wrap", {28'd0, q}, 32'd9);
    chk("dn_co", {31'd0, co}, 32'd1);
    dir = 1'b0;
    step(0, 1, 0, 0, 1); chk("updn_wrap", {28'd0, q}, 32'd0);
    chk("updn_co", {31'd0, co}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      dir = 1'($urandom_range(0, 1));
      step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), 1);
    end
    dir = 1'b0;
`endif
    // Random traffic, up only.
    for (int i = 0; i < 60; i++)
      step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
